booth_mult_seq: RTL

- Parametrised sequential signed (two's-complement) Booth multiplier.
- Combines its own control FSM and datapath, and is the successor to the fixed-width load/enable controller flow.
- Accepts operands through a start/ready handshake and iterates one Booth step per clock.
- Presents the 2*WIDTH-bit product through a valid/ready output handshake, with abort support. It sits between an operand source and a result consumer in the arithmetic unit.

---
 rtl/booth_mult_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Sequential signed (two's-complement) Booth multiplier. Takes one recoding
//   step per clock and delivers the exact 2*WIDTH-bit product.
//
//   Build option: define BOOTH_RADIX4_EN for radix-4 (modified Booth)
//   recoding, which needs WIDTH/2 steps instead of WIDTH. WIDTH must then be
//   even. The default build (macro undefined) uses radix-2.
//
//   Ports:
//     clk           rising-edge clock
//     reset         asynchronous, active-high reset
//     start         operand request, accepted only while ready=1
//     ready         high in IDLE
//     multiplicand  signed operand A, sampled on the accept edge
//     multiplier    signed operand B, sampled on the accept edge
//     abort         synchronous cancel of the operation in flight
//     busy          high in CALC
//     out_valid     product valid, high in DONE
//     out_ready     consumer accepts the product
//     product       signed A*B, stable while out_valid=1
module booth_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 abort,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_RADIX4_EN
    localparam int UW    = WIDTH + 2;   // upper accumulator holds +-2*A partials
    localparam int STEPS = WIDTH / 2;
`else
    localparam int UW    = WIDTH + 1;   // one guard bit so -(-2^(WIDTH-1)) fits
    localparam int STEPS = WIDTH;
`endif
    // P = {upper accumulator, multiplier bits, recoding bit}
    localparam int PW = UW + WIDTH + 1;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("booth_mult_seq: WIDTH must be >= 2");
        end
`ifdef BOOTH_RADIX4_EN
        if ((WIDTH % 2) != 0) begin : g_odd_width
            $error("booth_mult_seq: WIDTH must be even for radix-4 recoding");
        end
`endif
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [UW-1:0]        r_a;
    logic [PW-1:0]        r_p;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_out_valid;
    logic [2*WIDTH-1:0]   r_product;

    logic [UW-1:0]        w_upper;
    logic [UW-1:0]        w_sum;
    logic [PW-1:0]        w_cat;
    logic [PW-1:0]        w_p_next;
`ifdef BOOTH_RADIX4_EN
    logic [UW-1:0]        w_a2;
`endif

    // One Booth step: add the recoded partial into the upper part, then
    // arithmetic-shift the whole P register.
    always_comb begin
        w_upper = r_p[PW-1 -: UW];
        w_sum   = w_upper;
`ifdef BOOTH_RADIX4_EN
        w_a2 = {r_a[UW-2:0], 1'b0};
        case (r_p[2:0])
            3'b001, 3'b010: w_sum = w_upper + r_a;
            3'b011:         w_sum = w_upper + w_a2;
            3'b100:         w_sum = w_upper - w_a2;
            3'b101, 3'b110: w_sum = w_upper - r_a;
            default:        w_sum = w_upper;
        endcase
        w_cat    = {w_sum, r_p[WIDTH:0]};
        w_p_next = {{2{w_cat[PW-1]}}, w_cat[PW-1:2]};
`else
        case (r_p[1:0])
            2'b01:   w_sum = w_upper + r_a;
            2'b10:   w_sum = w_upper - r_a;
            default: w_sum = w_upper;
        endcase
        w_cat    = {w_sum, r_p[WIDTH:0]};
        w_p_next = {w_cat[PW-1], w_cat[PW-1:1]};
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // abort wins over start on the same edge
                    if (start && !abort) begin
                        r_a     <= {{(UW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand};
                        r_p     <= {{UW{1'b0}}, multiplier, 1'b0};
                        r_cnt   <= CNT_W'(STEPS);
                        r_state <= S_CALC;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_p   <= w_p_next;
                        r_cnt <= r_cnt - 1'b1;
                        // the final step lands the product straight in its register
                        if (r_cnt == CNT_W'(1)) begin
                            r_state     <= S_DONE;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_product   <= w_p_next[2*WIDTH:1];
                        end
                    end
                end
                S_DONE: begin
                    if (abort || out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule
